rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and busy scoreboard for the 32x32 integer register file. It shares the single register-file write port between NREQ writeback sources: ALU (0), load unit (1) and mul/div unit (2). It drives the port's RegWrite / WriteRegister / write-data inputs from registered outputs. It also keeps a per-register busy scoreboard that issue logic uses to stall RAW hazards on long-latency results.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters
- XLEN, 32, data width
- NREGS, 32, architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a result
- req_rd  in  NREQ*5  destination register per requester
- req_data  in  NREQ*XLEN  result per requester
- req_ready  out  NREQ  grant; transfer when valid & ready
- issue_valid  in  1  an instruction with a long-latency destination issues this cycle
- issue_rd  in  5  its destination register
- busy  out  NREGS  scoreboard; bit r = write to xr pending
- wb_regwrite  out  1  to register-file RegWrite
- wb_rd  out  5  to register-file WriteRegister
- wb_data  out  XLEN  to register-file write data

## Operation
- Arbitration is round-robin over requesters with req_valid=1. A pointer `rr_ptr` names the highest-priority index. At most one req_ready bit is high per cycle.
- req_ready is combinational from req_valid and rr_ptr. It is 0 for non-valid requesters.
- On a transfer from requester g, rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr holds.
- Requester rule, checked by assertion: once req_valid rises, it and req_rd/req_data stay stable until the transfer.
- The accepted rd/data are registered into wb_rd/wb_data. wb_regwrite <= 1 unless rd==0.
- An x0 transfer is accepted, handshaken normally and dropped: wb_regwrite=0, wb_rd/wb_data still load.
- With no transfer, wb_regwrite <= 0 and wb_rd/wb_data hold their values.
- Scoreboard set: issue_valid & issue_rd!=0 sets busy[issue_rd].
- Scoreboard clear: a cycle with wb_regwrite=1 clears busy[wb_rd] at the end of that cycle.
- If set and clear hit the same register on the same edge, set wins (a newer write is in flight).
- busy[0] is constant 0.

## Timing
- Reset (asynchronous, rst_n=0): wb_regwrite=0, wb_rd=0, wb_data=0, busy=0, rr_ptr=0. req_ready is forced 0 while rst_n=0.
- Latency: a transfer at edge T gives wb_* valid for exactly the cycle T..T+1. The register file writes at edge T+1. busy clears at edge T+1.
- Throughput: one write per cycle sustained. With all NREQ valid continuously, each requester is granted once every NREQ cycles.
- Worst-case wait: a valid requester is granted within NREQ cycles.
- Reset mid-operation: in-flight wb_* and busy bits are discarded. Requesters must deassert valid themselves.

## Structure
- Shared package `rf_pkg`:
  - XLEN, NREGS, REG_ADDR_W=5, NREQ
  - requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MUL=2
- Sub-module `rr_arbiter`: parameterised NREQ. Inputs req, ptr; output one-hot grant. It is purely combinational.
- Top level holds:
  - rr_ptr
  - the wb_* output registers
  - the busy scoreboard

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, wb_regwrite=0, busy=0. First grant after release goes to requester 0.
- Single write: req 1 valid with rd=5, data=0xDEADBEEF at cycle 0 -> ready_1=1 in cycle 0, wb_regwrite=1, wb_rd=5, wb_data=0xDEADBEEF in cycle 1, wb_regwrite=0 in cycle 2.
- Round-robin: all three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2 and one ready per cycle.
- x0 drop: req 0 writes rd=0, data=0x1234 -> handshake completes, wb_regwrite stays 0, busy[0] stays 0.
- Scoreboard: issue rd=7, then req 2 writes rd=7 three cycles later -> busy[7]=1 from the edge after issue until the end of the wb cycle, then 0.
- Set/clear collision: wb cycle writing rd=9 coincides with issue_valid rd=9 -> busy[9] remains 1 afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the integer register-file writeback path.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREQ       = 3;

  // Writeback requester indices
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MUL = 2;

  // Width of a pointer that names one of n requesters (at least one bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) receives a one-hot grant.
module rr_arbiter
  import rf_pkg::ptr_width;
#(
  parameter int NREQ = rf_pkg::NREQ
) (
  input  logic [NREQ-1:0]            req,
  input  logic [ptr_width(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]            grant
);

  localparam int PW = ptr_width(NREQ);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requesters starting at ptr; grant the first one that is asserted
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a per-register busy scoreboard.
// One writeback source wins the port per cycle (round-robin); the accepted
// rd/data are registered onto the port, and busy bits track writes that are
// issued but not yet written back.
module rf_wb_arbiter
  import rf_pkg::REG_ADDR_W, rf_pkg::ptr_width;
#(
  parameter int NREQ  = rf_pkg::NREQ,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int NREGS = rf_pkg::NREGS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]       req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       issue_valid,
  input  logic [REG_ADDR_W-1:0]      issue_rd,
  output logic [NREGS-1:0]           busy,
  output logic                       wb_regwrite,
  output logic [REG_ADDR_W-1:0]      wb_rd,
  output logic [XLEN-1:0]            wb_data
);

  localparam int PW = ptr_width(NREQ);

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  wb_regwrite_q, wb_regwrite_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [NREGS-1:0]      busy_q, busy_d;

  logic [NREQ-1:0]       grant;
  logic                  transfer;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Nothing may be granted while reset is asserted
  assign req_ready = grant & {NREQ{rst_n}};
  assign transfer  = |req_ready;

  // AND-OR mux chains select the winner's rd/data and the pointer that
  // follows it; at most one grant bit is set so the OR never merges values.
  logic [REG_ADDR_W-1:0] rd_or   [NREQ+1];
  logic [XLEN-1:0]       data_or [NREQ+1];
  logic [PW-1:0]         ptr_or  [NREQ+1];

  assign rd_or[0]   = '0;
  assign data_or[0] = '0;
  assign ptr_or[0]  = '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign rd_or[gi+1]   = rd_or[gi]   | (req_rd[gi*REG_ADDR_W +: REG_ADDR_W] & {REG_ADDR_W{req_ready[gi]}});
    assign data_or[gi+1] = data_or[gi] | (req_data[gi*XLEN +: XLEN] & {XLEN{req_ready[gi]}});
    assign ptr_or[gi+1]  = ptr_or[gi]  | (req_ready[gi] ? PW'((gi + 1) % NREQ) : '0);
  end

  // Next-state: pointer advance, writeback register load, scoreboard update
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    busy_d        = busy_q;

    if (transfer) begin
      rr_ptr_d      = ptr_or[NREQ];
      wb_rd_d       = rd_or[NREQ];
      wb_data_d     = data_or[NREQ];
      wb_regwrite_d = (rd_or[NREQ] != '0);
    end

    // Clear first so that a same-edge issue to the same register wins
    if (wb_regwrite_q) busy_d[wb_rd_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards any in-flight writeback and busy bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      busy_q        <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      busy_q        <= busy_d;
    end
  end

  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign busy        = busy_q;

  // A waiting requester must hold valid, rd and data until it is granted
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi]
         && $stable(req_rd[gi*REG_ADDR_W +: REG_ADDR_W])
         && $stable(req_data[gi*XLEN +: XLEN])));
  end

  a_one_grant: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round-robin order, single write,
// x0 drop, scoreboard set/clear, set/clear collision and mid-operation reset.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*REG_ADDR_W-1:0] req_rd;
  logic [NREQ*XLEN-1:0]       req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       issue_valid;
  logic [REG_ADDR_W-1:0]      issue_rd;
  logic [NREGS-1:0]           busy;
  logic                       wb_regwrite;
  logic [REG_ADDR_W-1:0]      wb_rd;
  logic [XLEN-1:0]            wb_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [XLEN-1:0] dtab [NREQ];

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [REG_ADDR_W-1:0] rd,
                         input logic [XLEN-1:0] data);
    req_valid[idx]                           = v;
    req_rd[idx*REG_ADDR_W +: REG_ADDR_W]     = rd;
    req_data[idx*XLEN +: XLEN]               = data;
  endtask

  initial begin
    dtab[0] = 32'hA000_0001;
    dtab[1] = 32'hA000_0002;
    dtab[2] = 32'hA000_0003;

    // Reset with every requester valid
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    set_req(REQ_ALU, 1'b1, 5'd1, dtab[0]);
    set_req(REQ_LSU, 1'b1, 5'd2, dtab[1]);
    set_req(REQ_MUL, 1'b1, 5'd3, dtab[2]);
    #3;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_regwrite", 64'(wb_regwrite), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_wb_rd", 64'(wb_rd), 64'h0);
    check("rst_wb_data", 64'(wb_data), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Round-robin with all valid; from cycle 5 each served requester leaves
    for (int c = 0; c < 8; c++) begin
      check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(1 << (c % 3)));
      tick();
      check($sformatf("rr_regwrite_c%0d", c), 64'(wb_regwrite), 64'h1);
      check($sformatf("rr_wb_rd_c%0d", c), 64'(wb_rd), 64'((c % 3) + 1));
      check($sformatf("rr_wb_data_c%0d", c), 64'(wb_data), 64'(dtab[c % 3]));
      if (c >= 5) req_valid[c % 3] = 1'b0;
      #1;
    end

    // Idle cycle: no grant, regwrite drops, rd/data hold
    check("idle_ready", 64'(req_ready), 64'h0);
    tick();
    check("idle_regwrite", 64'(wb_regwrite), 64'h0);
    check("idle_wb_rd_hold", 64'(wb_rd), 64'd2);
    check("idle_wb_data_hold", 64'(wb_data), 64'(dtab[1]));

    // Single write from the load unit (pointer now at 2)
    set_req(REQ_LSU, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("single_ready", 64'(req_ready), 64'b010);
    tick();
    check("single_regwrite", 64'(wb_regwrite), 64'h1);
    check("single_wb_rd", 64'(wb_rd), 64'd5);
    check("single_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
    req_valid[REQ_LSU] = 1'b0;
    tick();
    check("single_regwrite_off", 64'(wb_regwrite), 64'h0);
    check("single_wb_rd_hold", 64'(wb_rd), 64'd5);

    // x0 write: handshake completes but the port write is suppressed
    set_req(REQ_ALU, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    check("x0_ready", 64'(req_ready), 64'b001);
    tick();
    check("x0_regwrite", 64'(wb_regwrite), 64'h0);
    check("x0_wb_rd", 64'(wb_rd), 64'd0);
    check("x0_wb_data", 64'(wb_data), 64'h1234);
    check("x0_busy", 64'(busy), 64'h0);
    req_valid[REQ_ALU] = 1'b0;
    #1;

    // Scoreboard: issue x7, write x7 back three cycles later (pointer at 1)
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    check("sb_set", 64'(busy), 64'h80);
    issue_valid = 1'b0;
    tick();
    tick();
    check("sb_held", 64'(busy), 64'h80);
    set_req(REQ_MUL, 1'b1, 5'd7, 32'h0000_0077);
    #1;
    check("sb_ready", 64'(req_ready), 64'b100);
    tick();
    check("sb_wb_regwrite", 64'(wb_regwrite), 64'h1);
    check("sb_wb_rd", 64'(wb_rd), 64'd7);
    check("sb_busy_in_wb", 64'(busy), 64'h80);
    req_valid[REQ_MUL] = 1'b0;
    tick();
    check("sb_clear", 64'(busy), 64'h0);
    check("sb_regwrite_off", 64'(wb_regwrite), 64'h0);

    // Collision: wb cycle for x9 coincides with a new issue to x9 (pointer at 0)
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    check("col_set", 64'(busy), 64'h200);
    issue_valid = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd9, 32'h0000_0099);
    #1;
    check("col_ready", 64'(req_ready), 64'b001);
    tick();
    check("col_wb_regwrite", 64'(wb_regwrite), 64'h1);
    check("col_wb_rd", 64'(wb_rd), 64'd9);
    req_valid[REQ_ALU] = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    check("col_set_wins", 64'(busy), 64'h200);
    issue_valid = 1'b0;
    tick();
    check("col_still_busy", 64'(busy), 64'h200);
    set_req(REQ_LSU, 1'b1, 5'd9, 32'h0000_0999);
    #1;
    check("col2_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid[REQ_LSU] = 1'b0;
    tick();
    check("col2_clear", 64'(busy), 64'h0);

    // Mid-operation reset: discards wb and busy, pointer returns to 0
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    set_req(REQ_LSU, 1'b1, 5'd3, 32'h0000_0055);
    #1;
    check("mid_ready", 64'(req_ready), 64'b010);
    tick();
    check("mid_regwrite", 64'(wb_regwrite), 64'h1);
    check("mid_busy", 64'(busy), 64'h1000);
    issue_valid        = 1'b0;
    req_valid[REQ_LSU] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwrite", 64'(wb_regwrite), 64'h0);
    check("mid_rst_wb_rd", 64'(wb_rd), 64'h0);
    check("mid_rst_wb_data", 64'(wb_data), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    set_req(REQ_ALU, 1'b1, 5'd1, dtab[0]);
    set_req(REQ_LSU, 1'b1, 5'd2, dtab[1]);
    set_req(REQ_MUL, 1'b1, 5'd3, dtab[2]);
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_first_grant", 64'(req_ready), 64'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
